hex_mul_seq: RTL and testbench

Upstream sequencer for the nibble-serial multiplier stage. It captures an 8x8 unsigned operand pair on a start handshake and drives the 3-bit `state` code plus the two 4-bit nibble operands into the multiplier stage, one partial product per cycle. It accumulates the multiplier's registered 16-bit partial products, then presents the full 16-bit product with a one-cycle done pulse. The top level derives the multiplier stage's active-low reset from this block's `rst`.

---
 rtl/hex_mul_pkg.sv | 27 ++
 rtl/hex_mul_seq_if.sv | 40 ++++
 rtl/hex_mul_seq.sv | 126 ++++++++++++
 tb/tb_hex_mul_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_mul_pkg
//  Description : Shared definitions for the nibble-serial multiplier path.
//                Holds the 3-bit sequence codes seen by both the sequencer
//                and the multiplier stage, plus default operand/result
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package hex_mul_pkg;

   localparam int DATA_W_DEF = 8;              // operand width (only 8 supported)
   localparam int ACC_W_DEF  = 2 * DATA_W_DEF; // product / accumulator width

   // Sequence codes driven on the state bus. Code 7 is unused/illegal.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      C1   = 3'd1,
      C2   = 3'd2,
      C3   = 3'd3,
      C4   = 3'd4,
      C5   = 3'd5,
      C6   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_mul_seq_if
//  Description : Bundle between the requester / multiplier stage (master)
//                and the hex_mul_seq sequencer (slave).
//  Signals     : start, a_in, b_in  - operation request and operands
//                mul_out            - registered partial product from stage
//                busy, state        - sequencer status / sequence code
//                mul_in_1, mul_in_2 - nibble operands to multiplier stage
//                result, done       - accumulated product, 1-cycle valid
//  Revision    : 1.0 - initial release
// ============================================================================
interface hex_mul_seq_if
   import hex_mul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
);
   logic                  start;
   logic [DATA_W-1:0]     a_in;
   logic [DATA_W-1:0]     b_in;
   logic                  busy;
   logic [2:0]            state;
   logic [DATA_W/2-1:0]   mul_in_1;
   logic [DATA_W/2-1:0]   mul_in_2;
   logic [ACC_W-1:0]      mul_out;
   logic [ACC_W-1:0]      result;
   logic                  done;

   modport master (
      output start, a_in, b_in, mul_out,
      input  busy, state, mul_in_1, mul_in_2, result, done
   );

   modport slave (
      input  start, a_in, b_in, mul_out,
      output busy, state, mul_in_1, mul_in_2, result, done
   );
endinterface
`default_nettype wire

// File: rtl/hex_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : hex_mul_seq
//  Description : Sequencer for the nibble-serial 8x8 multiplier. Captures an
//                operand pair on start, walks C1..C6 issuing the four nibble
//                products, accumulates the stage's registered partial
//                products and pulses done with the 16-bit result.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - hex_mul_seq_if.slave (request, nibble drive,
//                       partial-product return, result/done)
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_mul_seq
   import hex_mul_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   hex_mul_seq_if.slave bus
);

   localparam int NIB_W = DATA_W / 2;

   state_t              state_q;
   state_t              state_d;
   logic [DATA_W-1:0]   a_reg;
   logic [DATA_W-1:0]   b_reg;
   logic [ACC_W-1:0]    acc;
   logic                done_q;
   logic                accept;
   logic                acc_en;
   logic [NIB_W-1:0]    nib_1;
   logic [NIB_W-1:0]    nib_2;

   // Starts are only honoured from IDLE; anything seen while busy is dropped.
   assign accept = (state_q == IDLE) && bus.start;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state, nibble drive and accumulate enable.
   // The stage returns each product one edge late, so the accumulate window
   // is shifted by one state relative to the nibble drive (C2..C5).
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = IDLE;
      acc_en  = 1'b0;
      nib_1   = '0;
      nib_2   = '0;
      case (state_q)
         IDLE: state_d = bus.start ? C1 : IDLE;
         C1: begin
            state_d = C2;
            nib_1   = a_reg[NIB_W-1:0];
            nib_2   = b_reg[NIB_W-1:0];
         end
         C2: begin
            state_d = C3;
            acc_en  = 1'b1;
            nib_1   = a_reg[DATA_W-1:NIB_W];
            nib_2   = b_reg[NIB_W-1:0];
         end
         C3: begin
            state_d = C4;
            acc_en  = 1'b1;
            nib_1   = a_reg[NIB_W-1:0];
            nib_2   = b_reg[DATA_W-1:NIB_W];
         end
         C4: begin
            state_d = C5;
            acc_en  = 1'b1;
            nib_1   = a_reg[DATA_W-1:NIB_W];
            nib_2   = b_reg[DATA_W-1:NIB_W];
         end
         C5: begin
            state_d = C6;
            acc_en  = 1'b1;
         end
         C6:      state_d = IDLE;
         default: state_d = IDLE;   // illegal code 7 recovers to IDLE
      endcase
   end

   // ---------------------------------------------------------------------
   // Operand capture, accumulator and done flag.
   // 0xFF*0xFF fits in 16 bits, so no carry-out is kept.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         acc    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == C5);
         if (accept) begin
            a_reg <= bus.a_in;
            b_reg <= bus.b_in;
            acc   <= '0;
         end else if (acc_en) begin
            acc <= acc + bus.mul_out;
         end
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.state    = state_q;
   assign bus.mul_in_1 = nib_1;
   assign bus.mul_in_2 = nib_2;
   assign bus.result   = acc;
   assign bus.done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_mul_seq
//  Description : Self-checking bench for hex_mul_seq. Includes a behavioural
//                model of the nibble multiplier stage, a vector table from
//                the known-answer cases, random operand pairs checked against
//                a*b, and hand sequences for ignored start and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_mul_seq;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   cyc;

   hex_mul_seq_if bus ();

   hex_mul_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier stage: registers the nibble product, shifted by position.
   function automatic logic [15:0] stage_prod(input logic [2:0] s,
                                              input logic [3:0] x,
                                              input logic [3:0] y);
      logic [15:0] p;
      p = 16'(x) * 16'(y);
      case (s)
         3'd1:      return p;
         3'd2, 3'd3: return p << 4;
         3'd4:      return p << 8;
         default:   return 16'h0000;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) bus.mul_out <= 16'h0000;
      else     bus.mul_out <= stage_prod(bus.state, bus.mul_in_1, bus.mul_in_2);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   // Runs one operation from IDLE; checks every cycle through the return
   // to IDLE. hold keeps start high afterwards; inj>0 pulses a competing
   // start with 0xFF operands in sequence cycle inj.
   task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input bit hold, input int inj,
                         output int done_at);
      logic [3:0] e1, e2;
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      done_at   = -1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) begin
            if (!hold) bus.start = 1'b0;
            bus.a_in = 8'($urandom);
            bus.b_in = 8'($urandom);
         end
         if (inj != 0 && k == inj) begin
            bus.start = 1'b1;
            bus.a_in  = 8'hFF;
            bus.b_in  = 8'hFF;
         end
         if (inj != 0 && k == inj + 1) bus.start = 1'b0;
         case (k)
            1:       begin e1 = a[3:0]; e2 = b[3:0]; end
            2:       begin e1 = a[7:4]; e2 = b[3:0]; end
            3:       begin e1 = a[3:0]; e2 = b[7:4]; end
            4:       begin e1 = a[7:4]; e2 = b[7:4]; end
            default: begin e1 = 4'h0;   e2 = 4'h0;   end
         endcase
         chk($sformatf("op%0d k%0d state", id, k), 32'(bus.state), (k == 7) ? 0 : k);
         chk($sformatf("op%0d k%0d busy", id, k), 32'(bus.busy), (k == 7) ? 0 : 1);
         chk($sformatf("op%0d k%0d mul_in_1", id, k), 32'(bus.mul_in_1), 32'(e1));
         chk($sformatf("op%0d k%0d mul_in_2", id, k), 32'(bus.mul_in_2), 32'(e2));
         chk($sformatf("op%0d k%0d done", id, k), 32'(bus.done), (k == 6) ? 1 : 0);
         if (k >= 6)
            chk($sformatf("op%0d k%0d result", id, k), 32'(bus.result), 32'(exp));
         if (bus.done === 1'b1) done_at = cyc;
      end
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
      bit          hold;
      int          inj;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int d_at;
      int prev_d;
      logic [7:0] ra, rb;

      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      prev_d  = -1;

      vecs[0] = '{a: 8'h12, b: 8'h34, exp: 16'h03A8, hold: 1'b0, inj: 0};
      vecs[1] = '{a: 8'hFF, b: 8'hFF, exp: 16'hFE01, hold: 1'b0, inj: 0};
      vecs[2] = '{a: 8'h00, b: 8'hA5, exp: 16'h0000, hold: 1'b1, inj: 0};
      vecs[3] = '{a: 8'hA5, b: 8'h3C, exp: 16'h26AC, hold: 1'b0, inj: 0};
      vecs[4] = '{a: 8'h10, b: 8'h10, exp: 16'h0100, hold: 1'b0, inj: 3};

      // Reset state
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a_in  = 8'h00;
      bus.b_in  = 8'h00;
      tick();
      tick();
      chk("reset state", 32'(bus.state), 0);
      chk("reset busy", 32'(bus.busy), 0);
      chk("reset result", 32'(bus.result), 0);
      chk("reset done", 32'(bus.done), 0);
      chk("reset mul_in_1", 32'(bus.mul_in_1), 0);
      chk("reset mul_in_2", 32'(bus.mul_in_2), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("idle after reset state", 32'(bus.state), 0);

      // Known-answer table, including back-to-back held start and ignored start
      for (int i = 0; i < 5; i++) begin
         run_op(i, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, vecs[i].inj, d_at);
         if (i == 3) chk("issue interval", 32'(d_at - prev_d), 7);
         prev_d = d_at;
      end

      // Reset in C3 aborts immediately without a done pulse
      bus.start = 1'b1;
      bus.a_in  = 8'h55;
      bus.b_in  = 8'h77;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      chk("pre-abort state", 32'(bus.state), 3);
      #2;
      rst = 1'b1;
      #1;
      chk("abort state", 32'(bus.state), 0);
      chk("abort busy", 32'(bus.busy), 0);
      chk("abort result", 32'(bus.result), 0);
      chk("abort done", 32'(bus.done), 0);
      chk("abort mul_in_1", 32'(bus.mul_in_1), 0);
      tick();
      chk("abort held done", 32'(bus.done), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("post-abort k%0d done", k), 32'(bus.done), 0);
         chk($sformatf("post-abort k%0d state", k), 32'(bus.state), 0);
      end
      run_op(10, 8'h03, 8'h05, 16'h000F, 1'b0, 0, d_at);

      // Random operand pairs against plain a*b
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run_op(100 + i, ra, rb, 16'(ra) * 16'(rb), 1'b0, 0, d_at);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
